mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 8 +
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter_timeout_ctr.sv | 19 +
 rtl/mem_port_arbiter.sv | 70 +++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// y86_mem_pkg: shared arbiter state encoding, stat codes and memory widths
package y86_mem_pkg;
    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int IFETCH_W = 80;
    typedef enum logic [1:0] {IDLE, DATA, INST} state_t;
    typedef enum logic [2:0] {SAOK = 3'd1, SHLT = 3'd2, SADR = 3'd3, SINS = 3'd4} stat_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and shared-memory signals of the arbiter
interface mem_port_arbiter_if;
    import y86_mem_pkg::*;
    logic                f_req;
    logic [ADDR_W-1:0]   f_addr;
    logic                f_done;
    logic [IFETCH_W-1:0] f_rdata;
    logic                f_err;
    logic                m_req;
    logic                m_write;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic                m_done;
    logic [DATA_W-1:0]   m_rdata;
    logic                m_err;
    logic                mem_req;
    logic                mem_write;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [IFETCH_W-1:0] mem_rdata;
    logic                mem_ack;
    logic                mem_err;
    logic                f_stall_req;
    logic                m_stall_req;
    modport slave (
        input  f_req, f_addr, m_req, m_write, m_addr, m_wdata, mem_rdata, mem_ack, mem_err,
        output f_done, f_rdata, f_err, m_done, m_rdata, m_err,
               mem_req, mem_write, mem_addr, mem_wdata, f_stall_req, m_stall_req
    );
    modport master (
        output f_req, f_addr, m_req, m_write, m_addr, m_wdata, mem_rdata, mem_ack, mem_err,
        input  f_done, f_rdata, f_err, m_done, m_rdata, m_err,
               mem_req, mem_write, mem_addr, mem_wdata, f_stall_req, m_stall_req
    );
endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// mem_timeout_ctr: counts cycles without ack and flags the last allowed one
module mem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] cnt;
    // wait counter: cleared while idle, advances on each unacknowledged busy cycle
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 8'd1;
    // expiry fires in the cycle whose increment would reach the limit
    assign expired = enable && (cnt == 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: data-priority arbitration of fetch and data ports onto one memory
module mem_port_arbiter
    import y86_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input logic clk,
    input logic reset,
    mem_port_arbiter_if.slave bus
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              busy, expired, fin, err_nx, grant_d, grant_f;
    assign busy   = state != IDLE;
    assign fin    = busy && (bus.mem_ack || expired);
    assign err_nx = (bus.mem_ack && bus.mem_err) || expired;
    mem_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk(clk), .reset(reset), .clear(!busy), .enable(busy && !bus.mem_ack), .expired(expired)
    );
    // next state: data wins in idle; a port whose done is up is not regranted
    always_comb begin
        grant_d  = state == IDLE && bus.m_req && !bus.m_done;
        grant_f  = state == IDLE && !grant_d && bus.f_req && !bus.f_done;
        state_nx = grant_d ? DATA : grant_f ? INST : fin ? IDLE : state;
    end
    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    // capture the granted request so later input changes cannot disturb it
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else if (grant_d) begin
            addr_q  <= bus.m_addr;
            wr_q    <= bus.m_write;
            wdata_q <= bus.m_wdata;
        end else if (grant_f) begin
            addr_q  <= bus.f_addr;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end
    // completion pulses with error and registered read data
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.f_done  <= 1'b0;
            bus.f_err   <= 1'b0;
            bus.f_rdata <= '0;
            bus.m_done  <= 1'b0;
            bus.m_err   <= 1'b0;
            bus.m_rdata <= '0;
        end else begin
            bus.f_done <= state == INST && fin;
            bus.f_err  <= state == INST && fin && err_nx;
            bus.m_done <= state == DATA && fin;
            bus.m_err  <= state == DATA && fin && err_nx;
            if (state == INST && fin) bus.f_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
            if (state == DATA && fin) bus.m_rdata <= (bus.mem_ack && !wr_q) ? bus.mem_rdata[DATA_W-1:0] : '0;
        end
    assign bus.mem_req     = busy;
    assign bus.mem_write   = state == DATA && wr_q;
    assign bus.mem_addr    = busy ? addr_q : '0;
    assign bus.mem_wdata   = state == DATA ? wdata_q : '0;
    assign bus.m_stall_req = bus.m_req && !bus.m_done;
    assign bus.f_stall_req = bus.f_req && !bus.f_done;
endmodule
